maze_frame_ctrl: RTL and testbench

- Sequencer that feeds the 17x17 MAZE solver core one map frame at a time and supervises its answer.
- Accepts a parallel 289-bit map from an upstream valid/ready source and serialises it onto the core's in_valid/in interface.
- Forwards the core's 2-bit move stream, tracks the walker position and counts steps.
- Reports a per-frame summary with error status (timeout, step overflow, out-of-bounds / wrong end cell).

---
 rtl/maze_frame_ctrl.sv | 139 +++++++++++++
 tb/tb_maze_frame_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_frame_ctrl.sv
// Frame sequencer for the 17x17 maze solver core: serialises one map per frame,
// forwards the move stream, tracks the walker and reports a per-frame summary.
module maze_frame_ctrl #(
    parameter int unsigned MAP_BITS  = 289,
    parameter int unsigned TIMEOUT   = 3000,
    parameter int unsigned MAX_STEPS = 289,
    parameter int unsigned STEP_W    = 9,
    parameter int unsigned TO_W      = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frm_valid,
    output logic                frm_ready,
    input  logic [MAP_BITS-1:0] frm_map,
    output logic                core_in_valid,
    output logic                core_in,
    input  logic                core_out_valid,
    input  logic [1:0]          core_out,
    output logic                mv_valid,
    output logic [1:0]          mv_dir,
    output logic [4:0]          pos_x,
    output logic [4:0]          pos_y,
    output logic                busy,
    output logic                done_valid,
    output logic [STEP_W-1:0]   done_steps,
    output logic [1:0]          done_err
);
    localparam int unsigned CNT_W = $clog2(MAP_BITS);
    localparam logic [4:0]  EDGE  = 5'd16;

    typedef enum logic [2:0] {StIdle, StSend, StWait, StRun, StDone} state_e;

    state_e              state;
    logic [MAP_BITS-1:0] shift;
    logic [CNT_W-1:0]    bit_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic [STEP_W-1:0]   steps;
    logic [1:0]          err;
    logic [4:0]          nx;
    logic [4:0]          ny;
    logic                oob;
    logic                move_fire;
    logic                at_max;

    assign move_fire     = core_out_valid && (state == StWait || state == StRun);
    assign at_max        = (steps == STEP_W'(MAX_STEPS));
    assign frm_ready     = (state == StIdle);
    assign busy          = (state != StIdle);
    assign core_in_valid = (state == StSend);
    assign core_in       = shift[0];
    assign done_valid    = (state == StDone);
    assign done_steps    = done_valid ? steps : '0;

    // A clean run that stops anywhere but the far corner is reported as a wrong end.
    always_comb begin
        done_err = 2'd0;
        if (done_valid) begin
            if (err == 2'd0 && (pos_x != EDGE || pos_y != EDGE)) done_err = 2'd3;
            else                                                 done_err = err;
        end
    end

    always_comb begin
        nx  = pos_x;
        ny  = pos_y;
        oob = 1'b0;
        unique case (core_out)
            2'd0: if (pos_x == EDGE)  oob = 1'b1; else nx = pos_x + 5'd1;
            2'd1: if (pos_y == EDGE)  oob = 1'b1; else ny = pos_y + 5'd1;
            2'd2: if (pos_x == 5'd0)  oob = 1'b1; else nx = pos_x - 5'd1;
            2'd3: if (pos_y == 5'd0)  oob = 1'b1; else ny = pos_y - 5'd1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            shift    <= '0;
            bit_cnt  <= '0;
            to_cnt   <= '0;
            steps    <= '0;
            err      <= 2'd0;
            pos_x    <= 5'd0;
            pos_y    <= 5'd0;
            mv_valid <= 1'b0;
            mv_dir   <= 2'd0;
        end else begin
            mv_valid <= move_fire;
            if (move_fire) begin
                mv_dir <= core_out;
                pos_x  <= nx;
                pos_y  <= ny;
                if (!at_max) steps <= steps + 1'b1;
                // First error wins; later ones are dropped.
                if (err == 2'd0) begin
                    if (at_max)   err <= 2'd2;
                    else if (oob) err <= 2'd3;
                end
            end

            case (state)
                StIdle: begin
                    if (frm_valid) begin
                        shift   <= frm_map;
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                        steps   <= '0;
                        err     <= 2'd0;
                        pos_x   <= 5'd0;
                        pos_y   <= 5'd0;
                        state   <= StSend;
                    end
                end
                StSend: begin
                    shift   <= shift >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(MAP_BITS - 1)) state <= StWait;
                end
                StWait: begin
                    if (core_out_valid) begin
                        state <= StRun;
                    end else if (to_cnt == TO_W'(TIMEOUT)) begin
                        if (err == 2'd0) err <= 2'd1;
                        state <= StDone;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                StRun: begin
                    if (!core_out_valid) state <= StDone;
                end
                StDone: begin
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_maze_frame_ctrl.sv
// Directed self-checking bench for maze_frame_ctrl.
module tb_maze_frame_ctrl;
    localparam int MAP_BITS = 289;
    localparam int TIMEOUT  = 3000;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                frm_valid = 1'b0;
    logic                frm_ready;
    logic [MAP_BITS-1:0] frm_map = '0;
    logic                core_in_valid;
    logic                core_in;
    logic                core_out_valid = 1'b0;
    logic [1:0]          core_out = 2'd0;
    logic                mv_valid;
    logic [1:0]          mv_dir;
    logic [4:0]          pos_x;
    logic [4:0]          pos_y;
    logic                busy;
    logic                done_valid;
    logic [8:0]          done_steps;
    logic [1:0]          done_err;

    maze_frame_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .frm_valid      (frm_valid),
        .frm_ready      (frm_ready),
        .frm_map        (frm_map),
        .core_in_valid  (core_in_valid),
        .core_in        (core_in),
        .core_out_valid (core_out_valid),
        .core_out       (core_out),
        .mv_valid       (mv_valid),
        .mv_dir         (mv_dir),
        .pos_x          (pos_x),
        .pos_y          (pos_y),
        .busy           (busy),
        .done_valid     (done_valid),
        .done_steps     (done_steps),
        .done_err       (done_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [MAP_BITS-1:0] map_a;
    logic [MAP_BITS-1:0] map_b;

    // Passive monitors: count and log activity, sampled on the falling edge.
    int       cyc = 0;
    int       cin_cnt = 0;
    int       mv_cnt = 0;
    int       done_cnt = 0;
    int       done_cyc = 0;
    int       fall_cyc = 0;
    logic     prev_civ = 1'b0;
    logic [8:0] last_steps = '0;
    logic [1:0] last_err = '0;
    bit       cap [0:4095];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (core_in_valid) begin
            if (cin_cnt < 4096) cap[cin_cnt] <= core_in;
            cin_cnt <= cin_cnt + 1;
        end
        if (mv_valid) mv_cnt <= mv_cnt + 1;
        if (done_valid) begin
            done_cnt   <= done_cnt + 1;
            done_cyc   <= cyc;
            last_steps <= done_steps;
            last_err   <= done_err;
        end
        if (prev_civ && !core_in_valid) fall_cyc <= cyc;
        prev_civ <= core_in_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [MAP_BITS-1:0] m, output bit ok);
        ok        = 1'b0;
        frm_map   = m;
        frm_valid = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (frm_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        frm_valid = 1'b0;
    endtask

    task automatic wait_send(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!core_in_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic drive_moves(input logic [1:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            core_out_valid = 1'b1;
            core_out       = d;
            tick();
        end
    endtask

    task automatic wait_done(input int bound, input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (core_in_valid !== 1'b0) begin bad++; $display("FAIL reset_civ: got %0d want 0", core_in_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0d want 0", busy); end
        total++; if (frm_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0d want 1", frm_ready); end
        total++; if (mv_valid !== 1'b0) begin bad++; $display("FAIL reset_mv: got %0d want 0", mv_valid); end
        total++; if (done_valid !== 1'b0) begin bad++; $display("FAIL reset_done: got %0d want 0", done_valid); end
        total++; if (pos_x !== 5'd0 || pos_y !== 5'd0) begin bad++; $display("FAIL reset_pos: got %0d,%0d want 0,0", pos_x, pos_y); end
        total++; if (done_steps !== 9'd0 || done_err !== 2'd0) begin bad++; $display("FAIL reset_summary: got %0d/%0d want 0/0", done_steps, done_err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_normal();
        int bc, bm, bd, lag_bad, bit_bad;
        bit ok;
        logic [1:0] d;
        bc = cin_cnt; bm = mv_cnt; bd = done_cnt;
        send_frame(map_a, ok);
        total++; if (!ok) begin bad++; $display("FAIL normal_accept: got 0 want 1"); end
        total++; if (core_in_valid !== 1'b1 || core_in !== map_a[0]) begin bad++; $display("FAIL normal_first_bit: got %0d/%0d want 1/%0d", core_in_valid, core_in, map_a[0]); end
        wait_send(ok);
        total++; if (!ok) begin bad++; $display("FAIL normal_send_end: got 0 want 1"); end
        total++; if (cin_cnt - bc != MAP_BITS) begin bad++; $display("FAIL normal_bit_count: got %0d want %0d", cin_cnt - bc, MAP_BITS); end
        bit_bad = 0;
        for (int i = 0; i < MAP_BITS; i++) if (cap[bc + i] !== map_a[i]) bit_bad++;
        total++; if (bit_bad != 0) begin bad++; $display("FAIL normal_bits: got %0d wrong want 0", bit_bad); end
        total++; if (mv_valid !== 1'b0) begin bad++; $display("FAIL normal_mv_idle: got %0d want 0", mv_valid); end
        lag_bad = 0;
        for (int i = 0; i < 32; i++) begin
            d = (i < 16) ? 2'd0 : 2'd1;
            core_out_valid = 1'b1;
            core_out       = d;
            tick();
            if (mv_valid !== 1'b1 || mv_dir !== d) lag_bad++;
        end
        core_out_valid = 1'b0;
        tick();
        total++; if (lag_bad != 0) begin bad++; $display("FAIL normal_mv_lag: got %0d wrong want 0", lag_bad); end
        total++; if (done_valid !== 1'b1) begin bad++; $display("FAIL normal_done_lat: got %0d want 1", done_valid); end
        total++; if (mv_valid !== 1'b0) begin bad++; $display("FAIL normal_mv_stop: got %0d want 0", mv_valid); end
        total++; if (done_steps !== 9'd32 || done_err !== 2'd0) begin bad++; $display("FAIL normal_summary: got %0d/%0d want 32/0", done_steps, done_err); end
        tick();
        total++; if (done_valid !== 1'b0 || frm_ready !== 1'b1) begin bad++; $display("FAIL normal_done_pulse: got %0d/%0d want 0/1", done_valid, frm_ready); end
        total++; if (pos_x !== 5'd16 || pos_y !== 5'd16) begin bad++; $display("FAIL normal_pos: got %0d,%0d want 16,16", pos_x, pos_y); end
        total++; if (mv_cnt - bm != 32 || done_cnt - bd != 1) begin bad++; $display("FAIL normal_counts: got %0d/%0d want 32/1", mv_cnt - bm, done_cnt - bd); end
    endtask

    task automatic test_timeout();
        int bd, late_bad;
        bit ok;
        bd = done_cnt;
        send_frame(map_b, ok);
        wait_send(ok);
        total++; if (!ok) begin bad++; $display("FAIL timeout_send: got 0 want 1"); end
        wait_done(TIMEOUT + 100, bd, ok);
        total++; if (!ok) begin bad++; $display("FAIL timeout_no_done: got 0 want 1"); end
        total++; if (done_cyc - fall_cyc != TIMEOUT + 1) begin bad++; $display("FAIL timeout_latency: got %0d want %0d", done_cyc - fall_cyc, TIMEOUT + 1); end
        total++; if (last_err !== 2'd1 || last_steps !== 9'd0) begin bad++; $display("FAIL timeout_summary: got %0d/%0d want 1/0", last_err, last_steps); end
        late_bad = 0;
        core_out_valid = 1'b1;
        core_out       = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mv_valid !== 1'b0 || busy !== 1'b0) late_bad++;
        end
        core_out_valid = 1'b0;
        total++; if (late_bad != 0) begin bad++; $display("FAIL timeout_late_move: got %0d wrong want 0", late_bad); end
    endtask

    task automatic test_oob();
        int bd;
        bit ok;
        bd = done_cnt;
        send_frame(map_a, ok);
        wait_send(ok);
        drive_moves(2'd2, 1);
        total++; if (pos_x !== 5'd0 || pos_y !== 5'd0 || mv_valid !== 1'b1) begin bad++; $display("FAIL oob_pos: got %0d,%0d mv=%0d want 0,0 mv=1", pos_x, pos_y, mv_valid); end
        drive_moves(2'd0, 16);
        drive_moves(2'd1, 16);
        core_out_valid = 1'b0;
        wait_done(10, bd, ok);
        total++; if (!ok) begin bad++; $display("FAIL oob_no_done: got 0 want 1"); end
        total++; if (last_err !== 2'd3 || last_steps !== 9'd33) begin bad++; $display("FAIL oob_summary: got %0d/%0d want 3/33", last_err, last_steps); end
    endtask

    task automatic test_wrong_end();
        int bd;
        bit ok;
        bd = done_cnt;
        send_frame(map_b, ok);
        wait_send(ok);
        drive_moves(2'd0, 16);
        core_out_valid = 1'b0;
        wait_done(10, bd, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrong_no_done: got 0 want 1"); end
        total++; if (last_err !== 2'd3 || last_steps !== 9'd16) begin bad++; $display("FAIL wrong_summary: got %0d/%0d want 3/16", last_err, last_steps); end
        total++; if (pos_x !== 5'd16 || pos_y !== 5'd0) begin bad++; $display("FAIL wrong_pos: got %0d,%0d want 16,0", pos_x, pos_y); end
    endtask

    task automatic test_back_to_back();
        int bc, bm, bd, ready_hi, bit_bad;
        bit ok;
        send_frame(map_a, ok);
        frm_map   = map_b;
        frm_valid = 1'b1;
        ready_hi  = 0;
        for (int i = 0; i < 400 && core_in_valid; i++) begin
            if (frm_ready) ready_hi++;
            tick();
        end
        total++; if (ready_hi != 0) begin bad++; $display("FAIL bp_ready_in_send: got %0d want 0", ready_hi); end
        drive_moves(2'd0, 16);
        drive_moves(2'd1, 16);
        core_out_valid = 1'b0;
        tick();
        total++; if (done_valid !== 1'b1 || frm_ready !== 1'b0) begin bad++; $display("FAIL bp_done: got %0d/%0d want 1/0", done_valid, frm_ready); end
        total++; if (done_steps !== 9'd32 || done_err !== 2'd0) begin bad++; $display("FAIL bp_summary: got %0d/%0d want 32/0", done_steps, done_err); end
        tick();
        total++; if (frm_ready !== 1'b1 || core_in_valid !== 1'b0) begin bad++; $display("FAIL bp_idle: got %0d/%0d want 1/0", frm_ready, core_in_valid); end
        tick();
        frm_valid = 1'b0;
        total++; if (core_in_valid !== 1'b1 || core_in !== map_b[0] || frm_ready !== 1'b0) begin bad++; $display("FAIL bp_second_accept: got %0d/%0d/%0d want 1/%0d/0", core_in_valid, core_in, frm_ready, map_b[0]); end
        bc = cin_cnt; bm = mv_cnt; bd = done_cnt;
        wait_send(ok);
        total++; if (cin_cnt - bc != MAP_BITS) begin bad++; $display("FAIL bp_bit_count: got %0d want %0d", cin_cnt - bc, MAP_BITS); end
        bit_bad = 0;
        for (int i = 0; i < MAP_BITS; i++) if (cap[bc + i] !== map_b[i]) bit_bad++;
        total++; if (bit_bad != 0) begin bad++; $display("FAIL bp_bits: got %0d wrong want 0", bit_bad); end
        for (int k = 0; k < 145; k++) begin
            drive_moves(2'd0, 1);
            drive_moves(2'd2, 1);
        end
        core_out_valid = 1'b0;
        wait_done(10, bd, ok);
        total++; if (!ok) begin bad++; $display("FAIL ovf_no_done: got 0 want 1"); end
        total++; if (last_err !== 2'd2 || last_steps !== 9'd289) begin bad++; $display("FAIL ovf_summary: got %0d/%0d want 2/289", last_err, last_steps); end
        total++; if (mv_cnt - bm != 290) begin bad++; $display("FAIL ovf_mv_count: got %0d want 290", mv_cnt - bm); end
    endtask

    task automatic test_reset_mid_send();
        int bc, bd, bit_bad;
        bit ok;
        bd = done_cnt;
        send_frame(map_a, ok);
        for (int i = 0; i < 99; i++) tick();
        total++; if (core_in_valid !== 1'b1 || core_in !== map_a[99]) begin bad++; $display("FAIL rst_bit100: got %0d/%0d want 1/%0d", core_in_valid, core_in, map_a[99]); end
        rst = 1'b1;
        tick();
        total++; if (core_in_valid !== 1'b0 || busy !== 1'b0 || frm_ready !== 1'b1) begin bad++; $display("FAIL rst_abort: got %0d/%0d/%0d want 0/0/1", core_in_valid, busy, frm_ready); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++; if (done_cnt != bd) begin bad++; $display("FAIL rst_no_done: got %0d want %0d", done_cnt - bd, 0); end
        bc = cin_cnt;
        send_frame(map_b, ok);
        wait_send(ok);
        total++; if (cin_cnt - bc != MAP_BITS) begin bad++; $display("FAIL rst_bit_count: got %0d want %0d", cin_cnt - bc, MAP_BITS); end
        bit_bad = 0;
        for (int i = 0; i < MAP_BITS; i++) if (cap[bc + i] !== map_b[i]) bit_bad++;
        total++; if (bit_bad != 0) begin bad++; $display("FAIL rst_bits: got %0d wrong want 0", bit_bad); end
        drive_moves(2'd0, 16);
        drive_moves(2'd1, 16);
        core_out_valid = 1'b0;
        wait_done(10, bd, ok);
        total++; if (!ok || last_err !== 2'd0 || last_steps !== 9'd32) begin bad++; $display("FAIL rst_next_frame: got ok=%0d %0d/%0d want ok=1 0/32", ok, last_err, last_steps); end
    endtask

    initial begin
        map_a = {1'b1, {9{32'hA5C3_1E97}}};
        map_b = {1'b0, {9{32'h3C96_F00D}}};
        test_reset();
        test_normal();
        test_timeout();
        test_oob();
        test_wrong_end();
        test_back_to_back();
        test_reset_mid_send();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
